pe_feeder: RTL

PE_FEEDER -- requirements
Module: pe_feeder

---
 rtl/pe_feeder.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/pe_feeder.sv
// Feeds Input and Weight words from two small FIFOs to a processing element and
// sequences the PE instruction lines (start / run-enable / stall) over one job.

module PeFeederFifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    input  logic          wvalid_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          pop_i,
    output logic          full_o,
    output logic          empty_o,
    output logic [DW-1:0] data_o
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW:0]   wPtr_q, wPtr_d;
    logic [AW:0]   rPtr_q, rPtr_d;
    logic          push;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    assign empty_o = (wPtr_q == rPtr_q);
    assign full_o  = (wPtr_q[AW] != rPtr_q[AW]) && (wPtr_q[AW-1:0] == rPtr_q[AW-1:0]);
    assign push    = wvalid_i && !full_o;
    assign data_o  = empty_o ? '0 : mem_q[rPtr_q[AW-1:0]];

    always_comb begin
        wPtr_d = wPtr_q;
        rPtr_d = rPtr_q;
        if (push) begin
            wPtr_d = wPtr_q + 1'b1;
        end
        if (pop_i && !empty_o) begin
            rPtr_d = rPtr_q + 1'b1;
        end
        if (flush_i) begin
            wPtr_d = '0;
            rPtr_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wPtr_q <= '0;
            rPtr_q <= '0;
        end else begin
            wPtr_q <= wPtr_d;
            rPtr_q <= rPtr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wPtr_q[AW-1:0]] <= wdata_i;
        end
    end
endmodule

module pe_feeder #(
    parameter int DW    = 16,
    parameter int DEPTH = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_go,
    input  logic          i_abort,
    input  logic [9:0]    i_in_cnt,
    input  logic [13:0]   i_w_cnt,
    output logic          o_busy,
    output logic          o_done,
    input  logic          i_in_wvalid,
    input  logic [DW-1:0] i_in_wdata,
    output logic          o_in_wfull,
    input  logic          i_w_wvalid,
    input  logic [DW-1:0] i_w_wdata,
    output logic          o_w_wfull,
    output logic          Input_rdy,
    input  logic          Input_ack,
    output logic [DW-1:0] o_Input_data,
    output logic          Weight_rdy,
    input  logic          Weight_ack,
    output logic [DW-1:0] o_Weight_data,
    output logic          o_inst_start,
    output logic          o_inst_reset,
    output logic          o_inst_stall
);
    typedef enum logic [2:0] {
        IDLE,
        START,
        RUN,
        STALL,
        DONE
    } state_e;

    state_e      state_q, state_d;
    logic [9:0]  inRem_q, inRem_d;
    logic [13:0] wRem_q, wRem_d;
    logic        instStart_q, instReset_q, instStall_q;
    logic        inEmpty, wEmpty;
    logic        inPop, wPop;
    logic        flush;
    logic        streaming;
    logic        inStarved, wStarved;

    PeFeederFifo #(.DW(DW), .DEPTH(DEPTH)) inFifo (
        .clk_i    (i_clk),
        .rst_i    (i_rst),
        .flush_i  (flush),
        .wvalid_i (i_in_wvalid),
        .wdata_i  (i_in_wdata),
        .pop_i    (inPop),
        .full_o   (o_in_wfull),
        .empty_o  (inEmpty),
        .data_o   (o_Input_data)
    );

    PeFeederFifo #(.DW(DW), .DEPTH(DEPTH)) wFifo (
        .clk_i    (i_clk),
        .rst_i    (i_rst),
        .flush_i  (flush),
        .wvalid_i (i_w_wvalid),
        .wdata_i  (i_w_wdata),
        .pop_i    (wPop),
        .full_o   (o_w_wfull),
        .empty_o  (wEmpty),
        .data_o   (o_Weight_data)
    );

    assign streaming  = (state_q == RUN) || (state_q == STALL);
    assign Input_rdy  = streaming && !inEmpty && (inRem_q != '0);
    assign Weight_rdy = streaming && !wEmpty && (wRem_q != '0);
    assign inPop      = Input_rdy && Input_ack;
    assign wPop       = Weight_rdy && Weight_ack;
    assign inStarved  = (inRem_q != '0) && inEmpty;
    assign wStarved   = (wRem_q != '0) && wEmpty;

    assign o_busy       = (state_q != IDLE);
    assign o_done       = (state_q == DONE);
    assign o_inst_start = instStart_q;
    assign o_inst_reset = instReset_q;
    assign o_inst_stall = instStall_q;

    // Job completion wins over the stall test; abort overrides everything.
    always_comb begin
        state_d = state_q;
        inRem_d = inRem_q;
        wRem_d  = wRem_q;
        flush   = 1'b0;
        if (inPop) begin
            inRem_d = inRem_q - 10'd1;
        end
        if (wPop) begin
            wRem_d = wRem_q - 14'd1;
        end
        case (state_q)
            IDLE: begin
                if (i_go && (i_in_cnt != '0) && (i_w_cnt != '0)) begin
                    state_d = START;
                    inRem_d = i_in_cnt;
                    wRem_d  = i_w_cnt;
                end
            end
            START: state_d = RUN;
            RUN, STALL: begin
                if ((inRem_q == '0) && (wRem_q == '0)) begin
                    state_d = DONE;
                    flush   = 1'b1;
                end else if (inStarved || wStarved) begin
                    state_d = STALL;
                end else begin
                    state_d = RUN;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (i_abort) begin
            state_d = IDLE;
            inRem_d = '0;
            wRem_d  = '0;
            flush   = 1'b1;
        end
    end

    // Instruction lines are decoded from the next state so they line up with state_q.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            inRem_q     <= '0;
            wRem_q      <= '0;
            instStart_q <= 1'b0;
            instReset_q <= 1'b0;
            instStall_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            inRem_q     <= inRem_d;
            wRem_q      <= wRem_d;
            instStart_q <= (state_d == START);
            instReset_q <= (state_d == START) || (state_d == RUN) || (state_d == STALL);
            instStall_q <= (state_d == STALL);
        end
    end
endmodule
